// File: rtl/lsu_avalon_host_if.sv
// Avalon-MM read/write bus shared by the LSU host adapter and its agent.
// Handshake: the host holds read or write, with address, byteenable and
// host_to_agent stable, until a cycle with waitrequest=0 (the accept cycle).
// Read data is taken from agent_to_host in any cycle where readdatavalid=1.
// That cycle may be the accept cycle itself, or a later one.
interface AvalonMmRw;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        waitrequest;
  logic        readdatavalid;

  modport Host (
    output address, byteenable, read, write, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );

  modport Agent (
    input  address, byteenable, read, write, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/lsu_avalon_host.sv
// Load/store host adapter: turns one CPU data request at a time into an
// Avalon-MM transaction. It handles lane steering, byte enables, sign
// extension, misalignment faults and the waitrequest/readdatavalid handshake.
// Optional feature: define LSU_HOST_TIMEOUT_EN to abort accesses that stay
// in CMD/RDWAIT for TIMEOUT_CYCLES cycles. The abort reports a fault.
// dbg_state_o exposes the FSM state (0 IDLE, 1 CMD, 2 RDWAIT, 3 RESP).
module lsu_avalon_host #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  dbg_state_o,
  AvalonMmRw.Host     bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CMD = 2'd1, S_RDWAIT = 2'd2, S_RESP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        is_write_q, unsigned_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        handshake, misaligned, accept, capture, done, timeout_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, shifted, load_data;

  assign handshake = req_valid && req_ready;
  assign accept    = (state_q == S_CMD) && !bus.waitrequest;
  assign capture   = (accept && !is_write_q && bus.readdatavalid) ||
                     ((state_q == S_RDWAIT) && bus.readdatavalid);
  assign done      = (accept && is_write_q) || capture;

`ifdef LSU_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_q, tmo_d;

  // Abort fires only if the access has not completed in the same cycle.
  assign timeout_hit = ((state_q == S_CMD) || (state_q == S_RDWAIT)) &&
                       (tmo_q == TMO_LAST) && !done;

  // Counter restarts on entry to CMD and counts every CMD/RDWAIT cycle.
  always_comb begin
    tmo_d = tmo_q;
    if (handshake) tmo_d = '0;
    else if ((state_q == S_CMD) || (state_q == S_RDWAIT)) tmo_d = tmo_q + {{(CW-1){1'b0}}, 1'b1};
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Request decode: alignment check, lane enables and lane-steered store data.
  always_comb begin
    misaligned = (req_size == 2'd3) ||
                 ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    case (req_size)
      2'd0:    be_new = 4'b0001 << req_addr[1:0];
      2'd1:    be_new = 4'b0011 << req_addr[1:0];
      default: be_new = 4'b1111;
    endcase
    wdata_new = (req_wdata << {req_addr[1:0], 3'b000}) &
                {{8{be_new[3]}}, {8{be_new[2]}}, {8{be_new[1]}}, {8{be_new[0]}}};
  end

  // Load extraction: shift the addressed lane down, then extend it.
  always_comb begin
    shifted = bus.agent_to_host >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_data = {{24{shifted[7] & ~unsigned_q}}, shifted[7:0]};
      2'd1:    load_data = {{16{shifted[15] & ~unsigned_q}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (handshake) state_d = misaligned ? S_RESP : S_CMD;
      S_CMD: begin
        if (accept) state_d = (is_write_q || bus.readdatavalid) ? S_RESP : S_RDWAIT;
        else if (timeout_hit) state_d = S_RESP;
      end
      S_RDWAIT: if (bus.readdatavalid || timeout_hit) state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: strobes decode straight from the state so reset drops them at once.
  always_comb begin
    req_ready      = (state_q == S_IDLE);
    rsp_valid      = (state_q == S_RESP);
    bus.read       = (state_q == S_CMD) && !is_write_q;
    bus.write      = (state_q == S_CMD) && is_write_q;
    bus.address    = addr_q;
    bus.byteenable = be_q;
    bus.host_to_agent = wdata_q;
    rsp_rdata      = rdata_q;
    rsp_fault      = fault_q;
    dbg_state_o    = state_q;
  end

  // Response next value: set on fault, capture or abort, cleared as RESP exits.
  always_comb begin
    rdata_d = rdata_q;
    fault_d = fault_q;
    if (state_q == S_RESP) begin
      rdata_d = '0;
      fault_d = 1'b0;
    end else if (handshake && misaligned) begin
      rdata_d = '0;
      fault_d = 1'b1;
    end else if (capture) begin
      rdata_d = load_data;
    end else if (timeout_hit) begin
      rdata_d = '0;
      fault_d = 1'b1;
    end
  end

  // Request latch and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write_q <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (handshake) begin
        is_write_q <= req_write;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        off_q      <= req_addr[1:0];
        if (!misaligned) begin
          addr_q  <= {req_addr[31:2], 2'b00};
          be_q    <= be_new;
          wdata_q <= wdata_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_avalon_host.sv
`timescale 1ns/1ps
module tb_lsu_avalon_host;
  localparam int TMO   = 8;
  localparam int STUCK = 100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  AvalonMmRw bus();

  lsu_avalon_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .dbg_state_o(dbg_state), .bus(bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0, n_fail = 0;
  logic [32:0] exp_q[$];      // {fault, rdata}
  int          exp_cyc_q[$];
  bit          inflight = 0;
  logic [31:0] last_rdata;
  logic        last_fault;
  int          last_rsp_cyc = 0, last_hs = 0;

  logic [31:0] agent_mem[16];
  logic [31:0] model_mem[16];
  int          ws_cfg = 0, lat_cfg = 0, ws_cnt = 0, pending = 0;
  int          read_cycles = 0, write_cycles = 0;
  logic [3:0]  rd_idx;
  logic [31:0] exp_bus_addr, exp_bus_data, last_wr_addr, last_wr_data;
  logic [3:0]  exp_bus_be, last_wr_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- agent model ----------------
  initial begin
    bus.waitrequest = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.agent_to_host = '0;
    forever begin
      @(negedge clk);
      bus.readdatavalid = 1'b0;
      bus.waitrequest = 1'b0;
      if (!rst_n) begin
        pending = 0;
        ws_cnt = 0;
        continue;
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          bus.readdatavalid = 1'b1;
          bus.agent_to_host = agent_mem[rd_idx];
        end
      end
      if (bus.read || bus.write) begin
        if (bus.read) read_cycles++;
        else write_cycles++;
        check("bus_address", bus.address, exp_bus_addr);
        check("bus_byteenable", {28'b0, bus.byteenable}, {28'b0, exp_bus_be});
        if (bus.write) check("bus_wdata", bus.host_to_agent, exp_bus_data);
        if (ws_cnt < ws_cfg) begin
          bus.waitrequest = 1'b1;
          ws_cnt++;
        end else begin
          ws_cnt = 0;
          if (bus.write) begin
            last_wr_addr = bus.address;
            last_wr_be   = bus.byteenable;
            last_wr_data = bus.host_to_agent;
            for (int i = 0; i < 4; i++)
              if (bus.byteenable[i]) agent_mem[bus.address[5:2]][8*i +: 8] = bus.host_to_agent[8*i +: 8];
          end else begin
            rd_idx = bus.address[5:2];
            if (lat_cfg == 0) begin
              bus.readdatavalid = 1'b1;
              bus.agent_to_host = agent_mem[rd_idx];
            end else begin
              pending = lat_cfg;
            end
          end
        end
      end else begin
        ws_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
        check("rsp_fault", {31'b0, rsp_fault}, {31'b0, exp_q[0][32]});
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);
        last_rdata = rsp_rdata;
        last_fault = rsp_fault;
        last_rsp_cyc = cyc;
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        inflight = 0;
      end else begin
        check("rsp_valid_quiet", {31'b0, rsp_valid}, 32'd0);
        check("req_ready", {31'b0, req_ready}, {31'b0, !inflight});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ws, input int lat, input bit expect_rsp);
    int nb, off, lat_tot, hs;
    logic flt;
    logic [31:0] rd, bd, w;
    logic [3:0] be;
    longint v;
    nb = 1 << size;
    off = int'(addr[1:0]);
    flt = (size == 2'd3) || ((off % nb) != 0);
    rd = '0; bd = '0; be = '0;
    if (!flt) begin
      for (int i = 0; i < nb; i++) begin
        be[off + i] = 1'b1;
        bd[8*(off + i) +: 8] = wdata[8*i +: 8];
      end
      if (!wr) begin
        w = model_mem[addr[5:2]];
        v = (longint'(w) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
        if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        rd = 32'(v);
      end
    end
    lat_tot = flt ? 1 : (wr ? 2 + ws : 2 + ws + lat);
`ifdef LSU_HOST_TIMEOUT_EN
    if (!flt && ws >= STUCK) begin
      flt = 1'b1;
      rd = '0;
      lat_tot = 1 + TMO;
    end
`endif
    @(negedge clk);
    ws_cfg = ws;
    lat_cfg = lat;
    exp_bus_addr = {addr[31:2], 2'b00};
    exp_bus_be = be;
    exp_bus_data = bd;
    hs = cyc;
    last_hs = hs;
    req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    inflight = 1;
    if (expect_rsp) begin
      exp_q.push_back({flt, rd});
      exp_cyc_q.push_back(hs + lat_tot);
    end
    if (wr && !flt && ws < STUCK)
      for (int i = 0; i < 4; i++)
        if (be[i]) model_mem[addr[5:2]][8*i +: 8] = bd[8*i +: 8];
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (inflight && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (inflight) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no response within %0d cycles", budget);
      inflight = 0;
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    inflight = 0;
    #1;
    check("rst_read", {31'b0, bus.read}, 32'd0);
    check("rst_write", {31'b0, bus.write}, 32'd0);
    check("rst_address", bus.address, 32'd0);
    check("rst_byteenable", {28'b0, bus.byteenable}, 32'd0);
    check("rst_h2a", bus.host_to_agent, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  int rc0, wc0;
  initial begin
    for (int i = 0; i < 16; i++) begin
      agent_mem[i] = '0;
      model_mem[i] = '0;
    end
    agent_mem[8] = 32'h80FF7F01; model_mem[8] = 32'h80FF7F01;
    agent_mem[3] = 32'h11223344; model_mem[3] = 32'h11223344;

    #1;
    check("por_req_ready", {31'b0, req_ready}, 32'd1);
    check("por_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("por_read", {31'b0, bus.read}, 32'd0);
    check("por_write", {31'b0, bus.write}, 32'd0);
    check("por_address", bus.address, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // byte store
    wc0 = write_cycles;
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 0, 0, 1'b1); wait_done(20);
    check("sb_addr_lit", last_wr_addr, 32'h10);
    check("sb_be_lit", {28'b0, last_wr_be}, 32'h8);
    check("sb_lane_lit", {24'b0, last_wr_data[31:24]}, 32'hAB);
    check("sb_write_cycles", write_cycles - wc0, 1);
    check("sb_latency", last_rsp_cyc - last_hs, 2);

    // signed/unsigned loads from 0x20 = 0x80FF7F01
    do_req(1'b0, 2'd0, 1'b0, 32'h22, 0, 0, 0, 1'b1); wait_done(20);
    check("lb_lit", last_rdata, 32'hFFFFFFFF);
    do_req(1'b0, 2'd0, 1'b1, 32'h22, 0, 0, 0, 1'b1); wait_done(20);
    check("lbu_lit", last_rdata, 32'h000000FF);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 0, 0, 0, 1'b1); wait_done(20);
    check("lh_lit", last_rdata, 32'hFFFF80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 0, 0, 0, 1'b1); wait_done(20);
    check("lhu_lit", last_rdata, 32'h000080FF);
    do_req(1'b0, 2'd0, 1'b0, 32'h21, 0, 0, 1, 1'b1); wait_done(20);
    do_req(1'b0, 2'd1, 1'b0, 32'h0C, 0, 1, 0, 1'b1); wait_done(20);
    do_req(1'b0, 2'd2, 1'b1, 32'h0C, 0, 0, 0, 1'b1); wait_done(20);

    // wait states: 3 waitrequest cycles, data 2 cycles after accept
    rc0 = read_cycles;
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 0, 3, 2, 1'b1); wait_done(30);
    check("ws_read_cycles", read_cycles - rc0, 4);
    check("ws_latency", last_rsp_cyc - last_hs, 7);
    check("ws_data_lit", last_rdata, 32'h80FF7F01);

    // stores with read-back
    do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'h1234BEEF, 1, 0, 1'b1); wait_done(20);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 0, 0, 0, 1'b1); wait_done(20);
    check("sh_readback_lit", last_rdata, 32'hBEEF0000);
    do_req(1'b1, 2'd2, 1'b0, 32'h18, 32'hDEADBEEF, 2, 0, 1'b1); wait_done(20);
    do_req(1'b0, 2'd1, 1'b1, 32'h1A, 0, 0, 3, 1'b1); wait_done(20);
    check("lhu_dead_lit", last_rdata, 32'h0000DEAD);
    do_req(1'b0, 2'd0, 1'b0, 32'h19, 0, 0, 0, 1'b1); wait_done(20);
    check("lb_be_lit", last_rdata, 32'hFFFFFFBE);
    do_req(1'b1, 2'd0, 1'b0, 32'h0E, 32'hFFFFFF5A, 0, 0, 1'b1); wait_done(20);

    // misaligned and reserved size: no bus activity
    rc0 = read_cycles; wc0 = write_cycles;
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 0, 0, 0, 1'b1); wait_done(20);
    check("mis_lw_fault_lit", {31'b0, last_fault}, 32'd1);
    check("mis_lw_latency", last_rsp_cyc - last_hs, 1);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 0, 0, 0, 1'b1); wait_done(20);
    do_req(1'b0, 2'd1, 1'b0, 32'h21, 0, 0, 0, 1'b1); wait_done(20);
    do_req(1'b1, 2'd2, 1'b0, 32'h02, 32'h55555555, 0, 0, 1'b1); wait_done(20);
    check("mis_no_read", read_cycles - rc0, 0);
    check("mis_no_write", write_cycles - wc0, 0);

    // reset in RDWAIT
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 0, 0, 20, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_rst_state", {30'b0, dbg_state}, 32'd2);
    async_reset();
    repeat (30) @(negedge clk);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 0, 0, 0, 1'b1); wait_done(20);
    check("post_rst_lit", last_rdata, 32'h80FF7F01);

    // stuck agent
    rc0 = read_cycles;
`ifdef LSU_HOST_TIMEOUT_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 0, STUCK, 0, 1'b1); wait_done(50);
    check("tmo_read_cycles", read_cycles - rc0, TMO);
    check("tmo_fault_lit", {31'b0, last_fault}, 32'd1);
    ws_cfg = 0;
`else
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 0, STUCK, 0, 1'b0);
    repeat (1000) @(negedge clk);
    check("stuck_read_held", {31'b0, (read_cycles - rc0) >= 1000}, 32'd1);
    check("stuck_state", {30'b0, dbg_state}, 32'd1);
    ws_cfg = 0;
    async_reset();
`endif
    repeat (3) @(negedge clk);
    do_req(1'b0, 2'd0, 1'b1, 32'h0E, 0, 0, 0, 1'b1); wait_done(20);
    check("final_lbu_lit", last_rdata, 32'h0000005A);

    for (int i = 0; i < 16; i++) check("mem_image", agent_mem[i], model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end
endmodule
